ws2812_frame_driver: RTL

- Serial transmitter on the other end of the core's pixel interface.
- On each update_frame request it walks current_led from 0 to MAX_POS-1 and reads the core's per-LED green/red/blue intensities.
- Serializes each LED as 24 bits, GRB order, MSB first, onto a single WS2812-style NRZ data line, then holds the latch/reset low period.
- Sits between the LED racer core and the board's LED-strip pin.

---
 rtl/ws2812_frame_driver.sv | 92 +++++++++
 1 files changed

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver: fetches MAX_POS GRB pixels and serializes them onto a WS2812 NRZ line, then latches.
module ws2812_frame_driver #(
  parameter int MAX_POS      = 16,
  parameter int T0H_CLK      = 20,
  parameter int T1H_CLK      = 40,
  parameter int BIT_CLK      = 62,
  parameter int RESET_CLK    = 15000,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       update_frame,
  input  logic [7:0]                 led_green_intensity,
  input  logic [7:0]                 led_red_intensity,
  input  logic [7:0]                 led_blue_intensity,
  output logic [$clog2(MAX_POS)-1:0] current_led,
  output logic                       data_out,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int MAXC = (BIT_CLK > RESET_CLK) ? BIT_CLK : RESET_CLK;
  localparam int CW = $clog2(MAXC + 1);
  localparam int LW = $clog2(MAX_POS);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;
  state_t state;
  logic pending;
  logic [23:0] shift_reg;
  logic [4:0] bit_idx;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] high_clk;
  always_comb begin
    cnt_inc = clk_cnt + 1'b1;
    high_clk = shift_reg[23] ? CW'(T1H_CLK) : CW'(T0H_CLK);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pending <= 1'b0;
      shift_reg <= '0;
      bit_idx <= '0;
      clk_cnt <= '0;
      current_led <= '0;
      data_out <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // requests arriving mid-frame (including on the frame_done edge) collapse into one
      if (state != IDLE) pending <= pending | update_frame;
      case (state)
        IDLE: if (update_frame || pending) begin
          current_led <= '0;
          busy <= 1'b1;
          pending <= 1'b0;
          clk_cnt <= '0;
          state <= FETCH;
        end
        FETCH: if (clk_cnt == CW'(READ_LATENCY)) begin
          shift_reg <= {led_green_intensity, led_red_intensity, led_blue_intensity};
          bit_idx <= '0;
          clk_cnt <= '0;
          data_out <= 1'b1;
          state <= SEND;
        end else clk_cnt <= cnt_inc;
        SEND: begin
          clk_cnt <= cnt_inc;
          if (cnt_inc == high_clk) data_out <= 1'b0;
          if (cnt_inc == CW'(BIT_CLK)) begin
            clk_cnt <= '0;
            if (bit_idx != 5'd23) begin
              shift_reg <= {shift_reg[22:0], 1'b0};
              bit_idx <= bit_idx + 5'd1;
              data_out <= 1'b1;
            end else if (current_led != LW'(MAX_POS - 1)) begin
              current_led <= current_led + 1'b1;
              state <= FETCH;
            end else state <= LATCH;
          end
        end
        LATCH: if (cnt_inc == CW'(RESET_CLK)) begin
          frame_done <= 1'b1;
          busy <= 1'b0;
          current_led <= '0;
          clk_cnt <= '0;
          state <= IDLE;
        end else clk_cnt <= cnt_inc;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
